// File: rtl/stdp_pkg.sv
// Shared constants and helpers for the STDP synapse array: width offsets,
// default learning shifts, weight bounds and a saturating clamp.
package stdp_pkg;

  localparam int TRACE_EXTRA     = 2;
  localparam int ACC_EXTRA       = 4;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_FRAC        = 4;
  localparam int ONE             = 1 << DEF_FRAC;
  localparam int DEF_TRACE_SHIFT = 4;
  localparam int DEF_LTP_SHIFT   = 3;
  localparam int DEF_LTD_SHIFT   = 4;
  localparam int DEF_W_MIN       = 4;
  localparam int DEF_W_MAX       = 127;
  localparam int DEF_W_INIT      = 16;

  function automatic int sat_clamp(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// Decaying, saturating spike trace: next = t - (t >> SHIFT) + (spike ? ONE : 0).
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int TW      = DEF_WIDTH + TRACE_EXTRA,
  parameter int SHIFT   = DEF_TRACE_SHIFT,
  parameter int ONE_VAL = ONE
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          spike,
  output logic [TW-1:0] trace
);

  localparam logic [TW:0] INC = (TW+1)'(ONE_VAL);

  logic [TW:0] sum;

  always_comb begin
    sum = {1'b0, trace} - {1'b0, trace >> SHIFT} + (spike ? INC : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trace <= '0;
    else          trace <= sum[TW] ? '1 : sum[TW-1:0];
  end

endmodule

// File: rtl/stdp_synapse_array.sv
// N_PRE-input STDP synapse array with trace-based LTP/LTD, leaky synaptic
// current and weight readback. Define STDP_WEIGHT_LOAD_EN to add the weight-write port.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_PRE       = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FRAC        = DEF_FRAC,
  parameter int TRACE_SHIFT = DEF_TRACE_SHIFT,
  parameter int LTP_SHIFT   = DEF_LTP_SHIFT,
  parameter int LTD_SHIFT   = DEF_LTD_SHIFT,
  parameter int W_MIN       = DEF_W_MIN,
  parameter int W_MAX       = DEF_W_MAX,
  parameter int W_INIT      = DEF_W_INIT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          learn_en,
  input  logic [N_PRE-1:0]              pre_spike,
  input  logic                          post_spike,
  input  logic                          rd_req,
  input  logic [$clog2(N_PRE):0]        rd_idx,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic                          wr_valid,
  input  logic [$clog2(N_PRE):0]        wr_idx,
  input  logic [WIDTH-1:0]              wr_weight,
  output logic                          wr_ready,
`endif
  output logic signed [WIDTH-1:0]       i_syn,
  output logic                          rd_valid,
  output logic [WIDTH-1:0]              rd_weight
);

  localparam int TW = WIDTH + TRACE_EXTRA;
  localparam int AW = WIDTH + ACC_EXTRA;
  localparam int XW = AW + 2;
  localparam int SW = WIDTH + 3;
  localparam int IW = $clog2(N_PRE) + 1;
  localparam logic [AW-1:0] I_MAX = AW'((1 << (WIDTH - 1)) - 1);

  logic [TW-1:0]        pre_trace [N_PRE];
  logic [TW-1:0]        post_trace;
  logic [WIDTH-1:0]     w         [N_PRE];
  logic [WIDTH-1:0]     w_next    [N_PRE];
  logic signed [SW-1:0] ltp       [N_PRE];
  logic signed [SW-1:0] ltd       [N_PRE];
  logic signed [SW-1:0] net       [N_PRE];
  logic [XW-1:0]        spike_sum;
  logic [XW-1:0]        acc_sum;
  logic [AW-1:0]        syn_acc;
  logic [AW-1:0]        acc_next;
  logic [AW-1:0]        acc_scaled;
  logic signed [WIDTH-1:0] isyn_next;
  logic [WIDTH-1:0]     rd_sel;

  for (genvar g = 0; g < N_PRE; g++) begin : g_pre
    stdp_trace #(.TW(TW), .SHIFT(TRACE_SHIFT), .ONE_VAL(1 << FRAC)) u_pre_trace (
      .clk(clk), .reset_n(reset_n), .spike(pre_spike[g]), .trace(pre_trace[g])
    );
  end

  stdp_trace #(.TW(TW), .SHIFT(TRACE_SHIFT), .ONE_VAL(1 << FRAC)) u_post_trace (
    .clk(clk), .reset_n(reset_n), .spike(post_spike), .trace(post_trace)
  );

`ifdef STDP_WEIGHT_LOAD_EN
  // Writes only land in spike-free cycles, so they never collide with learning.
  assign wr_ready = !((|pre_spike) || post_spike);
`endif

  // Plasticity: pre-update traces, net LTP-LTD applied in one step.
  always_comb begin
    for (int i = 0; i < N_PRE; i++) begin
      ltp[i] = '0;
      ltd[i] = '0;
      if (pre_spike[i] && post_trace != '0) ltp[i] = SW'(post_trace >> LTP_SHIFT);
      if (post_spike && pre_trace[i] != '0) ltd[i] = SW'(pre_trace[i] >> LTD_SHIFT);
      net[i]    = SW'(w[i]) + ltp[i] - ltd[i];
      w_next[i] = learn_en ? WIDTH'(sat_clamp(int'(net[i]), W_MIN, W_MAX)) : w[i];
`ifdef STDP_WEIGHT_LOAD_EN
      if (wr_valid && wr_ready && wr_idx == IW'(i))
        w_next[i] = WIDTH'(sat_clamp(int'(wr_weight), W_MIN, W_MAX));
`endif
    end
  end

  // Synaptic current: leaky accumulator fed by pre-update weights.
  always_comb begin
    spike_sum = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (pre_spike[i]) spike_sum = spike_sum + XW'(w[i]);
    end
    acc_sum    = XW'(syn_acc) - XW'(syn_acc >> 2) + spike_sum;
    acc_next   = (acc_sum[XW-1:AW] != '0) ? '1 : acc_sum[AW-1:0];
    acc_scaled = acc_next >> FRAC;
    isyn_next  = $signed((acc_scaled > I_MAX) ? WIDTH'(I_MAX) : WIDTH'(acc_scaled));
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (rd_idx == IW'(i)) rd_sel = w[i];
    end
  end

  // State register: weights, accumulator, current output, read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PRE; i++) w[i] <= WIDTH'(W_INIT);
      syn_acc   <= '0;
      i_syn     <= '0;
      rd_valid  <= 1'b0;
      rd_weight <= '0;
    end else begin
      for (int i = 0; i < N_PRE; i++) w[i] <= w_next[i];
      syn_acc  <= acc_next;
      i_syn    <= isyn_next;
      rd_valid <= rd_req;
      if (rd_req) rd_weight <= rd_sel;
    end
  end

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Bench for stdp_synapse_array: table of per-cycle vectors with a read-response
// scoreboard, plus hand sequences for reset, weight floor/ceiling and writes.
`timescale 1ns/1ps
module tb_stdp_synapse_array;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              learn_en = 1'b0;
  logic [3:0]        pre_spike = '0;
  logic              post_spike = 1'b0;
  logic              rd_req = 1'b0;
  logic [2:0]        rd_idx = '0;
  logic signed [7:0] i_syn;
  logic              rd_valid;
  logic [7:0]        rd_weight;
`ifdef STDP_WEIGHT_LOAD_EN
  logic              wr_valid = 1'b0;
  logic [2:0]        wr_idx = '0;
  logic [7:0]        wr_weight = '0;
  logic              wr_ready;
`endif

  always #5 clk = ~clk;

  stdp_synapse_array dut (
    .clk(clk),
    .reset_n(reset_n),
    .learn_en(learn_en),
    .pre_spike(pre_spike),
    .post_spike(post_spike),
    .rd_req(rd_req),
    .rd_idx(rd_idx),
`ifdef STDP_WEIGHT_LOAD_EN
    .wr_valid(wr_valid),
    .wr_idx(wr_idx),
    .wr_weight(wr_weight),
    .wr_ready(wr_ready),
`endif
    .i_syn(i_syn),
    .rd_valid(rd_valid),
    .rd_weight(rd_weight)
  );

  typedef struct {
    logic       rst;
    logic [3:0] pre;
    logic       post;
    logic       learn;
    logic       rd;
    logic [2:0] idx;
    int         exp_rd;
    int         exp_isyn;
  } vec_t;

  vec_t tbl[$];
  int   exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] pre, input logic post,
                              input logic learn, input logic rd, input logic [2:0] idx,
                              input int exp_rd, input int exp_isyn);
    vec_t v;
    v.rst = rst; v.pre = pre; v.post = post; v.learn = learn;
    v.rd = rd; v.idx = idx; v.exp_rd = exp_rd; v.exp_isyn = exp_isyn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply_reset();
    pre_spike = '0; post_spike = 1'b0; learn_en = 1'b0; rd_req = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive, push expected read, sample #1 after the edge.
  task automatic step(input logic [3:0] pre, input logic post, input logic learn,
                      input logic rd, input logic [2:0] idx, input int exp_rd,
                      input int exp_isyn, input string tag);
    pre_spike = pre; post_spike = post; learn_en = learn; rd_req = rd; rd_idx = idx;
    if (rd) exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    check({tag, " rd_valid"}, int'(rd_valid), int'(rd));
    if (rd_valid) begin
      check({tag, " rd_queue"}, exp_q.size(), 1);
      if (exp_q.size() > 0) check({tag, " rd_weight"}, int'(rd_weight), exp_q.pop_front());
    end
    if (exp_isyn >= 0) check({tag, " i_syn"}, int'(i_syn), exp_isyn);
    pre_spike = '0; post_spike = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held: outputs quiet, read requests ignored.
    rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset i_syn", int'(i_syn), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset rd_weight", int'(rd_weight), 0);
    rd_req = 1'b0;
    reset_n = 1'b1;

    // rst, pre, post, learn, rd, idx, exp_rd, exp_isyn
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 2, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 3, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 5, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
    // single pre spike: acc 16 -> 12; trace 16 -> 15 gives no LTD
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 1, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 16, 0));
    // post then pre: LTP of 2
    tbl.push_back(mk(1, 4'b0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 18, 0));
    // pre then post: LTD of 1
    tbl.push_back(mk(1, 4'b0010, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 15, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 16, 0));
    // pairings with learning off
    tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 2, 16, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 3, 16, 0));
    // simultaneous pre+post: LTP 30>>3=3, LTD 16>>4=1, net +2
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0, 18, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) apply_reset();
      step(tbl[i].pre, tbl[i].post, tbl[i].learn, tbl[i].rd, tbl[i].idx,
           tbl[i].exp_rd, tbl[i].exp_isyn, $sformatf("vec%0d", i));
    end

    // Reset mid-operation drops the pending read and the in-flight update.
    apply_reset();
    step(4'b0000, 1, 1, 1, 0, 16, 0, "midrst_pre");
    pre_spike = 4'b0001; learn_en = 1'b1; rd_req = 1'b1; rd_idx = 3'd0;
    #3 reset_n = 1'b0;
    #1;
    check("midrst rd_valid", int'(rd_valid), 0);
    check("midrst rd_weight", int'(rd_weight), 0);
    check("midrst i_syn", int'(i_syn), 0);
    @(posedge clk); #1;
    pre_spike = '0; learn_en = 1'b0; rd_req = 1'b0;
    reset_n = 1'b1;
    step(4'b0000, 0, 0, 1, 0, 16, 0, "midrst_post");

    // Depression floors at W_MIN.
    apply_reset();
    repeat (64) step(4'b0010, 0, 0, 0, 0, 0, -1, "floor_build");
    step(4'b0000, 1, 1, 0, 0, 0, -1, "floor_ltd");
    step(4'b0000, 1, 1, 1, 1, 4, -1, "floor_ltd2");
    step(4'b0000, 0, 0, 1, 1, 4, -1, "floor_w1");
    step(4'b0000, 0, 0, 1, 0, 16, -1, "floor_w0");

    // Potentiation ceilings at W_MAX.
    apply_reset();
    repeat (64) step(4'b0000, 1, 0, 0, 0, 0, -1, "ceil_build");
    repeat (8) step(4'b0001, 0, 1, 0, 0, 0, -1, "ceil_ltp");
    step(4'b0000, 0, 0, 1, 0, 127, -1, "ceil_w0");
    step(4'b0001, 0, 1, 1, 0, 127, -1, "ceil_w0b");
    step(4'b0000, 0, 0, 1, 0, 127, -1, "ceil_w0c");

`ifdef STDP_WEIGHT_LOAD_EN
    apply_reset();
    wr_valid = 1'b1; wr_idx = 3'd2; wr_weight = 8'd200;
    #1;
    check("wr_ready quiet", int'(wr_ready), 1);
    step(4'b0000, 0, 0, 0, 0, 0, -1, "wr_clamp");
    wr_valid = 1'b0;
    step(4'b0000, 0, 0, 1, 2, 127, -1, "wr_rd2");
    wr_valid = 1'b1; wr_idx = 3'd3; wr_weight = 8'd50; pre_spike = 4'b0001;
    #1;
    check("wr_ready spike", int'(wr_ready), 0);
    step(4'b0001, 0, 0, 1, 3, 16, 1, "wr_blocked");
    #1;
    check("wr_ready after", int'(wr_ready), 1);
    step(4'b0000, 0, 0, 1, 3, 16, 0, "wr_quiet");
    wr_valid = 1'b0;
    step(4'b0000, 0, 0, 1, 3, 50, -1, "wr_rd3");
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
